// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter.
// Round-robin grant, held for the whole cyc, with a per-strobe wait timeout
// that terminates a stalled cycle with a synthetic ack and TIMEOUT_DATA.
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        arstn,
  // master 0 (CPU)
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic        m0_stb,
  input  logic        m0_cyc,
  output logic        m0_ack,
  // master 1 (e.g. DMA)
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic        m1_stb,
  input  logic        m1_cyc,
  output logic        m1_ack,
  // slave side
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic        s_stb,
  output logic        s_cyc,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  // status
  output logic [1:0]  grant,
  output logic        timeout
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [9:0] TimeoutCnt = 10'(TIMEOUT);

  state_e     state_q;
  logic       last_q;   // 1: m1 was the last owner, so m0 wins the next tie
  logic [9:0] wait_q;

  logic own_cyc, own_stb, other_cyc;
  logic owning, tmo, ack;

  // Select the owning master's request lines.
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    other_cyc = 1'b0;
    unique case (state_q)
      StOwn0: begin
        own_cyc   = m0_cyc;
        own_stb   = m0_stb;
        other_cyc = m1_cyc;
      end
      StOwn1: begin
        own_cyc   = m1_cyc;
        own_stb   = m1_stb;
        other_cyc = m0_cyc;
      end
      default: ;
    endcase
  end

  assign owning = (state_q != StIdle);
  // A strobe that has waited TIMEOUT cycles is terminated this cycle.
  assign tmo    = owning & own_stb & (wait_q == TimeoutCnt);
  // Late s_ack in the timeout cycle is folded into the single synthetic ack.
  assign ack    = owning & (tmo | (s_ack & own_stb));

  assign grant   = {state_q == StOwn1, state_q == StOwn0};
  assign m0_ack  = grant[0] & ack;
  assign m1_ack  = grant[1] & ack;
  assign timeout = tmo;

  assign s_cyc = own_cyc & ~tmo;
  assign s_stb = own_stb & ~tmo;

  assign m0_dat_o = tmo ? TIMEOUT_DATA : s_dat_i;
  assign m1_dat_o = tmo ? TIMEOUT_DATA : s_dat_i;

  // Slave-side address/data mux; driven to zero when nobody owns the bus.
  always_comb begin
    s_adr   = 32'h0;
    s_dat_o = 32'h0;
    s_we    = 1'b0;
    s_sel   = 4'h0;
    unique case (state_q)
      StOwn0: begin
        s_adr   = m0_adr;
        s_dat_o = m0_dat_i;
        s_we    = m0_we;
        s_sel   = m0_sel;
      end
      StOwn1: begin
        s_adr   = m1_adr;
        s_dat_o = m1_dat_i;
        s_we    = m1_we;
        s_sel   = m1_sel;
      end
      default: ;
    endcase
  end

  // Ownership FSM, round-robin memory and strobe wait counter.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      wait_q  <= 10'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wait_q <= 10'd0;
          if (m0_cyc && m1_cyc) begin
            state_q <= last_q ? StOwn0 : StOwn1;
          end else if (m0_cyc) begin
            state_q <= StOwn0;
          end else if (m1_cyc) begin
            state_q <= StOwn1;
          end
        end
        StOwn0, StOwn1: begin
          if (!own_cyc) begin
            // Release: hand straight to a waiting master, no idle bubble.
            last_q <= (state_q == StOwn1);
            wait_q <= 10'd0;
            if (other_cyc) begin
              state_q <= (state_q == StOwn0) ? StOwn1 : StOwn0;
            end else begin
              state_q <= StIdle;
            end
          end else if (tmo || s_ack || !own_stb) begin
            wait_q <= 10'd0;
          end else begin
            wait_q <= wait_q + 10'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: directed scenarios followed by
// random master/slave traffic, all checked against a transaction-level model.
module tb_wb_master_arbiter;

  localparam int unsigned TO = 8;
  localparam logic [31:0] TD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        arstn;
  always #5 clk = ~clk;

  logic        c  [2];
  logic        s  [2];
  logic        w  [2];
  logic [31:0] a  [2];
  logic [31:0] d  [2];
  logic [3:0]  sl [2];
  logic [31:0] s_dat_i;
  logic        s_ack;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr, s_dat_o;
  logic        m0_ack, m1_ack, s_we, s_stb, s_cyc, timeout;
  logic [3:0]  s_sel;
  logic [1:0]  grant;

  wb_master_arbiter #(
    .TIMEOUT      (TO),
    .TIMEOUT_DATA (TD)
  ) dut (
    .clk      (clk),
    .arstn    (arstn),
    .m0_adr   (a[0]),
    .m0_dat_i (d[0]),
    .m0_dat_o (m0_dat_o),
    .m0_we    (w[0]),
    .m0_sel   (sl[0]),
    .m0_stb   (s[0]),
    .m0_cyc   (c[0]),
    .m0_ack   (m0_ack),
    .m1_adr   (a[1]),
    .m1_dat_i (d[1]),
    .m1_dat_o (m1_dat_o),
    .m1_we    (w[1]),
    .m1_sel   (sl[1]),
    .m1_stb   (s[1]),
    .m1_cyc   (c[1]),
    .m1_ack   (m1_ack),
    .s_adr    (s_adr),
    .s_dat_o  (s_dat_o),
    .s_we     (s_we),
    .s_sel    (s_sel),
    .s_stb    (s_stb),
    .s_cyc    (s_cyc),
    .s_dat_i  (s_dat_i),
    .s_ack    (s_ack),
    .grant    (grant),
    .timeout  (timeout)
  );

  // Reference model: who owns the bus (-1 none), who owned it last, and how
  // many cycles the current strobe has gone unanswered.
  int own;
  int last;
  int waited;

  int tests;
  int fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own    = -1;
    last   = 1;
    waited = 0;
  endtask

  // Compare every DUT output against what the model says this cycle shows.
  task automatic check_all();
    logic        tmo, eack;
    logic [1:0]  eg;
    logic        esc, esst, ewe;
    logic [31:0] eadr, ewd;
    logic [3:0]  esel;
    tmo = 1'b0;
    if (own >= 0) tmo = s[own] && (waited == TO);
    if (own < 0) begin
      eg = 2'b00; esc = 1'b0; esst = 1'b0; eack = 1'b0;
      eadr = '0; ewd = '0; ewe = 1'b0; esel = '0;
    end else begin
      eg   = (own == 0) ? 2'b01 : 2'b10;
      esc  = tmo ? 1'b0 : c[own];
      esst = tmo ? 1'b0 : s[own];
      eack = tmo | (s_ack & s[own]);
      eadr = a[own]; ewd = d[own]; ewe = w[own]; esel = sl[own];
    end
    chk("grant",    32'(grant),    32'(eg));
    chk("s_cyc",    32'(s_cyc),    32'(esc));
    chk("s_stb",    32'(s_stb),    32'(esst));
    chk("m0_ack",   32'(m0_ack),   32'(eack && own == 0));
    chk("m1_ack",   32'(m1_ack),   32'(eack && own == 1));
    chk("timeout",  32'(timeout),  32'(tmo));
    chk("m0_dat_o", m0_dat_o,      tmo ? TD : s_dat_i);
    chk("m1_dat_o", m1_dat_o,      tmo ? TD : s_dat_i);
    chk("s_adr",    s_adr,         eadr);
    chk("s_dat_o",  s_dat_o,       ewd);
    chk("s_we",     32'(s_we),     32'(ewe));
    chk("s_sel",    32'(s_sel),    32'(esel));
  endtask

  // Advance the model across a rising edge using the inputs seen at that edge.
  task automatic model_edge();
    logic tmo;
    if (own < 0) begin
      waited = 0;
      if (c[0] && c[1]) own = (last == 1) ? 0 : 1;
      else if (c[0])    own = 0;
      else if (c[1])    own = 1;
    end else if (!c[own]) begin
      last   = own;
      waited = 0;
      own    = c[1-own] ? 1 - own : -1;
    end else begin
      tmo = s[own] && (waited == TO);
      if (tmo || s_ack || !s[own]) waited = 0;
      else waited++;
    end
  endtask

  // Inputs are changed at the falling edge; outputs are checked 2 time units
  // later, well clear of the rising edge.
  task automatic tick();
    #2;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      c[i] = 1'b0; s[i] = 1'b0; w[i] = 1'b0;
      a[i] = '0; d[i] = '0; sl[i] = '0;
    end
    s_ack   = 1'b0;
    s_dat_i = '0;
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    check_all();
    arstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle_inputs();
    do_reset();

    // Single master read, slave answers on the third owned cycle.
    c[0] = 1; s[0] = 1; a[0] = 32'h0000_1000; sl[0] = 4'hF;
    tick();
    #1 chk("t1_grant", 32'(grant), 32'h1);
    tick();
    tick();
    s_ack = 1; s_dat_i = 32'h1234_5678;
    #1;
    chk("t1_ack", 32'(m0_ack), 32'h1);
    chk("t1_dat", m0_dat_o, 32'h1234_5678);
    chk("t1_m1ack", 32'(m1_ack), 32'h0);
    tick();
    c[0] = 0; s[0] = 0; s_ack = 0;
    tick();
    tick();

    // Tie after reset, direct handover, second tie back to m0.
    do_reset();
    c[0] = 1; c[1] = 1; s[0] = 1; s[1] = 1; a[0] = 32'hA0; a[1] = 32'hB1;
    tick();
    #1 chk("t2_first", 32'(grant), 32'h1);
    s_ack = 1; s_dat_i = 32'hCAFE_0000;
    tick();
    c[0] = 0; s[0] = 0; s_ack = 0;
    tick();
    #1 chk("t2_handover", 32'(grant), 32'h2);
    s_ack = 1;
    tick();
    c[1] = 0; s[1] = 0; s_ack = 0;
    tick();
    c[0] = 1; c[1] = 1; s[0] = 1; s[1] = 1;
    tick();
    #1 chk("t2_tie2", 32'(grant), 32'h1);
    c[0] = 0; c[1] = 0; s[0] = 0; s[1] = 0;
    tick();
    tick();

    // m1 holds the bus for four strobes while m0 waits.
    c[1] = 1; s[1] = 1; w[1] = 1;
    tick();
    c[0] = 1; a[0] = 32'h0000_0C00;
    for (int k = 0; k < 4; k++) begin
      a[1] = 32'h2000 + 32'(k * 4); d[1] = $urandom; sl[1] = 4'(k + 1);
      s_ack = 1; s_dat_i = $urandom;
      #1;
      chk("t3_hold", 32'(grant), 32'h2);
      chk("t3_m1ack", 32'(m1_ack), 32'h1);
      tick();
    end
    c[1] = 0; s[1] = 0; w[1] = 0; s_ack = 0;
    tick();
    #1 chk("t3_m0_after", 32'(grant), 32'h1);
    c[0] = 0;
    tick();
    tick();

    // Timeout: slave never answers, the ninth strobe cycle is terminated.
    c[0] = 1; s[0] = 1; s_dat_i = 32'h5555_AAAA;
    tick();
    for (int k = 0; k < 8; k++) begin
      #1 chk("t4_wait_noack", 32'(m0_ack), 32'h0);
      tick();
    end
    s_ack = 1;  // late ack in the timeout cycle
    #1;
    chk("t4_ack", 32'(m0_ack), 32'h1);
    chk("t4_dat", m0_dat_o, 32'hFFFF_FFFF);
    chk("t4_pulse", 32'(timeout), 32'h1);
    chk("t4_stb", 32'(s_stb), 32'h0);
    tick();
    s_ack = 0;
    #1 chk("t4_pulse_end", 32'(timeout), 32'h0);
    tick();
    c[0] = 0; s[0] = 0;
    tick();
    tick();

    // Asynchronous reset while m1 owns the bus with a strobe pending.
    c[1] = 1; s[1] = 1;
    tick();
    tick();
    #2 arstn = 0;
    #1;
    chk("t5_grant", 32'(grant), 32'h0);
    chk("t5_cyc", 32'(s_cyc), 32'h0);
    model_reset();
    c[1] = 0; s[1] = 0;
    @(negedge clk);
    arstn = 1;
    @(negedge clk);
    c[0] = 1; c[1] = 1;
    tick();
    #1 chk("t5_tie", 32'(grant), 32'h1);
    c[0] = 0; c[1] = 0;
    tick();
    tick();

    // Spurious slave ack with nobody granted.
    s_ack = 1;
    #1;
    chk("t6_m0ack", 32'(m0_ack), 32'h0);
    chk("t6_m1ack", 32'(m1_ack), 32'h0);
    chk("t6_stb", 32'(s_stb), 32'h0);
    tick();
    s_ack = 0;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!c[i]) begin
          c[i] = ($urandom_range(0, 3) == 0);
        end else if ($urandom_range(0, 7) == 0) begin
          c[i] = 1'b0;
        end
        s[i]  = c[i] && ($urandom_range(0, 3) != 0);
        w[i]  = 1'($urandom);
        a[i]  = $urandom;
        d[i]  = $urandom;
        sl[i] = 4'($urandom);
      end
      s_ack   = ($urandom_range(0, 2) == 0);
      s_dat_i = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
